// File: rtl/pipelined_instruction_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipelined_instruction_decoder_pkg
// Brief  : MIPS32 op/funct encodings, type indices and decode helpers.
// Rev    : 1.0  initial release
// ============================================================================
package pipelined_instruction_decoder_pkg;

    localparam int NUM_TYPES   = 28;
    localparam int ILLEGAL_IDX = 28;
    localparam int NUM_STATS   = 29;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_DIVU    = 6'h1B;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    localparam int T_ADD  = 0,  T_ADDI = 1,  T_ADDIU = 2,  T_ADDU = 3;
    localparam int T_AND  = 4,  T_ANDI = 5,  T_SLL   = 6,  T_SRA  = 7;
    localparam int T_SRL  = 8,  T_SUB  = 9,  T_OR    = 10, T_ORI  = 11;
    localparam int T_NOR  = 12, T_LW   = 13, T_SW    = 14, T_BEQ  = 15;
    localparam int T_BNE  = 16, T_SLT  = 17, T_SLTI  = 18, T_SLTU = 19;
    localparam int T_J    = 20, T_JAL  = 21, T_JR    = 22, T_SYSCALL = 23;
    localparam int T_DIVU = 24, T_MFLO = 25, T_LB    = 26, T_BGTZ = 27;

    typedef struct packed {
        logic                 illegal;
        logic [NUM_TYPES-1:0] kind;
        logic [31:0]          instr;
    } dec_entry_t;

    function automatic logic [NUM_TYPES-1:0] decode_type(input logic [31:0] instr);
        logic [NUM_TYPES-1:0] t;
        t = '0;
        if (instr[31:26] == OP_RTYPE) begin
            case (instr[5:0])
                FN_SLL:     t[T_SLL]     = 1'b1;
                FN_SRL:     t[T_SRL]     = 1'b1;
                FN_SRA:     t[T_SRA]     = 1'b1;
                FN_JR:      t[T_JR]      = 1'b1;
                FN_SYSCALL: t[T_SYSCALL] = 1'b1;
                FN_MFLO:    t[T_MFLO]    = 1'b1;
                FN_DIVU:    t[T_DIVU]    = 1'b1;
                FN_ADD:     t[T_ADD]     = 1'b1;
                FN_ADDU:    t[T_ADDU]    = 1'b1;
                FN_SUB:     t[T_SUB]     = 1'b1;
                FN_AND:     t[T_AND]     = 1'b1;
                FN_OR:      t[T_OR]      = 1'b1;
                FN_NOR:     t[T_NOR]     = 1'b1;
                FN_SLT:     t[T_SLT]     = 1'b1;
                FN_SLTU:    t[T_SLTU]    = 1'b1;
                default:    t            = '0;
            endcase
        end else begin
            case (instr[31:26])
                OP_J:     t[T_J]     = 1'b1;
                OP_JAL:   t[T_JAL]   = 1'b1;
                OP_BEQ:   t[T_BEQ]   = 1'b1;
                OP_BNE:   t[T_BNE]   = 1'b1;
                OP_BGTZ:  t[T_BGTZ]  = 1'b1;
                OP_ADDI:  t[T_ADDI]  = 1'b1;
                OP_ADDIU: t[T_ADDIU] = 1'b1;
                OP_SLTI:  t[T_SLTI]  = 1'b1;
                OP_ANDI:  t[T_ANDI]  = 1'b1;
                OP_ORI:   t[T_ORI]   = 1'b1;
                OP_LB:    t[T_LB]    = 1'b1;
                OP_LW:    t[T_LW]    = 1'b1;
                OP_SW:    t[T_SW]    = 1'b1;
                default:  t          = '0;
            endcase
        end
        return t;
    endfunction

    // Illegal entries carry an all-zero type vector and map to the last counter.
    function automatic logic [4:0] type_index(input logic [NUM_TYPES-1:0] kind,
                                              input logic illegal);
        logic [4:0] idx;
        idx = 5'(ILLEGAL_IDX);
        if (!illegal) begin
            for (int i = 0; i < NUM_TYPES; i++) begin
                if (kind[i]) idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_instruction_decoder_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module : decoder_skid_buffer
// Brief  : Valid/ready storage, one register (depth 1) or skid pair (depth 2).
// Rev    : 1.0  initial release
// ============================================================================
module decoder_skid_buffer #(
    parameter int DATA_W    = 61,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              r_head_valid;
    logic [DATA_W-1:0] r_head_data;
    logic              w_push;
    logic              w_pop;

    assign w_push    = in_valid && in_ready;
    assign w_pop     = r_head_valid && out_ready;
    assign out_valid = r_head_valid;
    assign out_data  = r_head_data;

    if (BUF_DEPTH == 1) begin : g_depth1
        assign in_ready = !rst && (!r_head_valid || out_ready);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_head_valid <= 1'b0;
                r_head_data  <= '0;
            end else if (w_push) begin
                r_head_valid <= 1'b1;
                r_head_data  <= in_data;
            end else if (w_pop) begin
                r_head_valid <= 1'b0;
            end
        end
    end else begin : g_depth2
        logic              r_skid_valid;
        logic [DATA_W-1:0] r_skid_data;
        logic              r_ready;

        // r_ready tracks "skid slot empty"; rst gates it so it reads low in reset.
        assign in_ready = r_ready && !rst;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_head_valid <= 1'b0;
                r_head_data  <= '0;
                r_skid_valid <= 1'b0;
                r_skid_data  <= '0;
                r_ready      <= 1'b1;
            end else if (!r_head_valid || w_pop) begin
                if (r_skid_valid) begin
                    r_head_valid <= 1'b1;
                    r_head_data  <= r_skid_data;
                    r_skid_valid <= w_push;
                    r_ready      <= !w_push;
                    if (w_push) r_skid_data <= in_data;
                end else begin
                    r_head_valid <= w_push;
                    r_ready      <= 1'b1;
                    if (w_push) r_head_data <= in_data;
                end
            end else if (w_push) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= in_data;
                r_ready      <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_instruction_decoder.sv
`default_nettype none
// ============================================================================
// Module : pipelined_instruction_decoder
// Brief  : Handshaked MIPS32 instruction classifier with buffered output.
//          Define DECODER_STATS_EN to build the per-type retire counters.
// Rev    : 1.0  initial release
// ============================================================================
module pipelined_instruction_decoder
    import pipelined_instruction_decoder_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [NUM_TYPES-1:0] out_type,
    output logic                 out_illegal,
    input  logic                 clr_stats,
    input  logic [4:0]           stat_sel,
    output logic [CNT_WIDTH-1:0] stat_count
);

    dec_entry_t w_in_entry;
    dec_entry_t w_out_entry;

    always_comb begin
        w_in_entry         = '0;
        w_in_entry.instr   = in_instr;
        w_in_entry.kind    = decode_type(in_instr);
        w_in_entry.illegal = ~|w_in_entry.kind;
    end

    decoder_skid_buffer #(
        .DATA_W    ($bits(dec_entry_t)),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_entry)
    );

    assign out_instr   = w_out_entry.instr;
    assign out_type    = w_out_entry.kind;
    assign out_illegal = w_out_entry.illegal;

`ifdef DECODER_STATS_EN
    logic [CNT_WIDTH-1:0] r_cnt [NUM_STATS];
    logic [CNT_WIDTH-1:0] r_stat_count;
    logic [4:0]           w_head_idx;
    logic                 w_retire;

    assign w_retire   = out_valid && out_ready;
    assign w_head_idx = type_index(w_out_entry.kind, w_out_entry.illegal);
    assign stat_count = r_stat_count;

    // Clear has priority over a retire landing on the same edge.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            for (int i = 0; i < NUM_STATS; i++) r_cnt[i] <= '0;
        end else if (w_retire && (r_cnt[w_head_idx] != {CNT_WIDTH{1'b1}})) begin
            r_cnt[w_head_idx] <= r_cnt[w_head_idx] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_count <= '0;
        end else if (stat_sel < 5'(NUM_STATS)) begin
            r_stat_count <= r_cnt[stat_sel];
        end else begin
            r_stat_count <= '0;
        end
    end
`else
    logic w_unused_stats;
    assign w_unused_stats = ^{clr_stats, stat_sel};
    assign stat_count     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_instruction_decoder.sv
`default_nettype none
// ============================================================================
// Module : tb_pipelined_instruction_decoder
// Brief  : Directed self-checking bench (BUF_DEPTH=2, CNT_WIDTH=4).
// Rev    : 1.0  initial release
// ============================================================================
module tb_pipelined_instruction_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [27:0] out_type;
    logic        out_illegal;
    logic        clr_stats;
    logic [4:0]  stat_sel;
    logic [3:0]  stat_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipelined_instruction_decoder #(
        .BUF_DEPTH (2),
        .CNT_WIDTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_type    (out_type),
        .out_illegal (out_illegal),
        .clr_stats   (clr_stats),
        .stat_sel    (stat_sel),
        .stat_count  (stat_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        clr_stats = 1'b0; stat_sel = '0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
        checks++; if (out_type !== 28'h0) begin failures++; $display("FAIL reset_out_type got=%h exp=0", out_type); end
        checks++; if (out_illegal !== 1'b0) begin failures++; $display("FAIL reset_out_illegal got=%b exp=0", out_illegal); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (stat_count !== 4'h0) begin failures++; $display("FAIL reset_stat_count got=%h exp=0", stat_count); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_add();
        in_valid = 1'b1; in_instr = 32'h012A4020; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        checks++; if (out_type !== 28'h0000001) begin failures++; $display("FAIL add_type got=%h exp=0000001", out_type); end
        checks++; if (out_illegal !== 1'b0) begin failures++; $display("FAIL add_illegal got=%b exp=0", out_illegal); end
        checks++; if (out_instr !== 32'h012A4020) begin failures++; $display("FAIL add_instr got=%h exp=012a4020", out_instr); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_retired got=%b exp=0", out_valid); end
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; in_instr = 32'hFC000000; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_illegal !== 1'b1) begin failures++; $display("FAIL illegal_flag got=%b exp=1", out_illegal); end
        checks++; if (out_type !== 28'h0) begin failures++; $display("FAIL illegal_type got=%h exp=0", out_type); end
`ifdef DECODER_STATS_EN
        stat_sel = 5'd28;
        tick(); tick();
        checks++; if (stat_count !== 4'd1) begin failures++; $display("FAIL illegal_count got=%0d exp=1", stat_count); end
`else
        tick();
`endif
    endtask

    task automatic test_decode_table();
        logic [31:0] instrs [12];
        logic [27:0] types  [12];
        instrs = '{32'h00000000, 32'h8C880000, 32'h08000000, 32'h03E00008,
                   32'h0000000C, 32'h00000001, 32'h1C000000, 32'h80000000,
                   32'h00004012, 32'h0000001B, 32'h4C000000, 32'h21280005};
        types  = '{28'h0000040,  28'h0002000,  28'h0100000,  28'h0400000,
                   28'h0800000,  28'h0000000,  28'h8000000,  28'h4000000,
                   28'h2000000,  28'h1000000,  28'h0000000,  28'h0000002};
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_instr = instrs[i];
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_instr !== instrs[i]) begin
                failures++; $display("FAIL stream_head[%0d] got=%b/%h exp=1/%h", i, out_valid, out_instr, instrs[i]);
            end
            checks++; if (out_type !== types[i] || out_illegal !== (types[i] == 28'h0)) begin
                failures++; $display("FAIL stream_type[%0d] got=%h/%b exp=%h/%b", i, out_type, out_illegal, types[i], types[i] == 28'h0);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h21280005;
        tick();
        in_instr = 32'h35290001;
        tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready got=%b exp=0", in_ready); end
        in_instr = 32'hAD090004;
        tick(); tick();
        checks++; if (out_valid !== 1'b1 || out_instr !== 32'h21280005) begin
            failures++; $display("FAIL b2b_stall_head got=%b/%h exp=1/21280005", out_valid, out_instr);
        end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_ready got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_instr !== 32'h35290001 || out_type !== 28'h0000800) begin
            failures++; $display("FAIL b2b_second got=%h/%h exp=35290001/0000800", out_instr, out_type);
        end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_reopen got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_instr !== 32'hAD090004 || out_type !== 28'h0004000) begin
            failures++; $display("FAIL b2b_third got=%b/%h/%h exp=1/ad090004/0004000", out_valid, out_instr, out_type);
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_stats();
`ifdef DECODER_STATS_EN
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h8C880000;
        repeat (20) tick();
        in_valid = 1'b0;
        tick();
        stat_sel = 5'd13;
        tick();
        checks++; if (stat_count !== 4'd15) begin failures++; $display("FAIL sat_count got=%0d exp=15", stat_count); end
        stat_sel = 5'd30;
        tick();
        checks++; if (stat_count !== 4'd0) begin failures++; $display("FAIL sel_out_of_range got=%0d exp=0", stat_count); end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0; clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0; stat_sel = 5'd13;
        tick();
        checks++; if (stat_count !== 4'd0) begin failures++; $display("FAIL clr_wins got=%0d exp=0", stat_count); end
        stat_sel = 5'd28;
        tick();
        checks++; if (stat_count !== 4'd0) begin failures++; $display("FAIL clr_illegal got=%0d exp=0", stat_count); end
`else
        clr_stats = 1'b1;
        for (int s = 0; s < 32; s++) begin
            stat_sel = 5'(s);
            tick();
            checks++; if (stat_count !== 4'd0) begin failures++; $display("FAIL no_stats[%0d] got=%0d exp=0", s, stat_count); end
        end
        clr_stats = 1'b0;
`endif
    endtask

    task automatic test_rst_mid_stream();
        logic [31:0] stream [10];
        logic [31:0] q [$];
        int          idx;
        logic        acc;
        logic        ret;
        stream = '{32'h8C880000, 32'h8C880000, 32'h8C880000, 32'h21280005, 32'h35290001,
                   32'hAD090004, 32'h012A4020, 32'h08000000, 32'h21280005, 32'h35290001};
        idx = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            out_ready = (cyc % 2) == 1;
            rst       = (cyc == 7);
            in_valid  = idx < 10;
            in_instr  = (idx < 10) ? stream[idx] : 32'h0;
            #1;
            acc = in_valid && in_ready;
            ret = out_valid && out_ready;
            tick();
            if (rst) begin
                q.delete();
            end else begin
                if (ret) void'(q.pop_front());
                if (acc) q.push_back(in_instr);
            end
            if (acc) idx++;
            checks++; if (out_valid !== (q.size() != 0)) begin
                failures++; $display("FAIL mid_valid[%0d] got=%b exp=%b", cyc, out_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                checks++; if (out_instr !== q[0]) begin failures++; $display("FAIL mid_order[%0d] got=%h exp=%h", cyc, out_instr, q[0]); end
            end
            if (cyc == 7) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0", in_ready); end
            end
            if (cyc == 8) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_post_rst_ready got=%b exp=1", in_ready); end
            end
        end
        in_valid = 1'b0; rst = 1'b0;
`ifdef DECODER_STATS_EN
        stat_sel = 5'd13;
        tick();
        checks++; if (stat_count !== 4'd0) begin failures++; $display("FAIL mid_rst_counter got=%0d exp=0", stat_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_add();
        test_illegal();
        test_decode_table();
        test_back_to_back();
        test_stats();
        test_rst_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
